router_input_vc_buffer: RTL
===========================

Name: router_input_vc_buffer

Overview:
- Receive side of the router crossbar link; one instance per router input port.
- Accepts the flit and write-enable driven by the upstream router's crossbar output and steers each flit into a per-virtual-channel FIFO selected by flit.vc_id.
- Presents each VC's head flit to the local allocation stage.
- Returns per-VC on/off backpressure to the upstream router and checks the packet framing (HEADER/BODY/TAIL/HT) per VC.

Parameters:
- VC_NUM, `VC_PER_PORT (4): number of virtual channels, one FIFO each.
- FIFO_DEPTH, 16: flits per VC FIFO; power of two, >= 4.
- OFF_SLACK, 3: free-slot count at or below which on_off_out[vc] asserts; covers the link round-trip.

Ports:
- clk  in  1  router clock
- reset  in  1  asynchronous, active-high reset
- wr_en_in  in  1  flit valid from upstream crossbar wr_en_out
- flit_in  in  $bits(flit_t)  flit from upstream crossbar flit_out
- rd_en_in  in  VC_NUM  per-VC pop request from the allocation stage
- head_flit_out  out  VC_NUM x $bits(flit_t)  head flit of each VC FIFO
- head_valid_out  out  VC_NUM  VC FIFO non-empty
- on_off_out  out  VC_NUM  1 = upstream must stop sending on this VC
- overflow_err_out  out  VC_NUM  sticky: write while FIFO full
- framing_err_out  out  VC_NUM  sticky: illegal flit_type sequence

Behaviour:
- Reset (async, active-high): all FIFO pointers and counts cleared; every VC framing FSM set to IDLE.
  - Outputs during and after reset: head_valid_out=0, on_off_out=0, both error vectors=0.
  - head_flit_out reads the (don't-care) storage; the bench checks it only when head_valid_out=1.
- Write: on a rising edge with wr_en_in=1, flit_in is pushed into FIFO[flit_in.vc_id]. Only one VC is written per cycle.
- Read: on a rising edge with rd_en_in[v]=1 and the FIFO non-empty, FIFO[v] pops. Several VCs may pop in the same cycle.
  - rd_en_in[v] on an empty FIFO is ignored: no pointer change, no error.
- Head outputs are first-word-fall-through, driven directly from storage at the read pointer.
  - Write-to-head latency is 1 cycle; there is no same-cycle bypass.
  - After a pop, the next entry is visible in the following cycle.
- Simultaneous push and pop on the same VC:
  - If non-empty: both take effect and the count is unchanged.
  - If empty: the push takes effect; the pop is ignored.
  - If full: the pop frees a slot, so the push is accepted with no overflow.
- Overflow: a push to a full FIFO with no same-cycle pop drops the flit. Pointers are unchanged and overflow_err_out[v] sets until reset.
- Count and pointers: pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits, with range 0..FIFO_DEPTH.
- on_off_out[v] is registered:
  - Value after an edge = 1 iff (FIFO_DEPTH - count_next) <= OFF_SLACK.
  - It deasserts on the first edge where free slots exceed OFF_SLACK (no hysteresis).
- Framing FSM per VC, advanced only on an accepted push to that VC:
  - IDLE: HEADER -> IN_PKT; HT -> IDLE; BODY or TAIL -> set framing_err_out[v], stay IDLE.
  - IN_PKT: BODY -> IN_PKT; TAIL -> IDLE; HEADER or HT -> set framing_err_out[v], stay IN_PKT.
  - A flit that raises a framing error is still stored; the FIFO never drops on a framing error.
- Reset mid-packet: all stored flits are discarded, the FSM returns to IDLE, and on_off_out returns to 0.

Test Plan:
- Reset, then push HEADER, BODY, TAIL on vc 2 in consecutive cycles:
  - head_valid_out = 4'b0100 one cycle after the first push; head is the HEADER.
  - After a single rd_en_in[2], the head is the BODY.
  - framing_err_out stays 0.
- Push 13 flits on vc 0 with FIFO_DEPTH=16 and OFF_SLACK=3 -> on_off_out[0]=1 after the 13th push edge. One pop -> on_off_out[0]=0 after that edge.
- Fill vc 1 to 16 flits, then push a 17th:
  - The flit is dropped and overflow_err_out[1]=1.
  - Popping 16 times returns the 16 original flits in order.
- Repeat the fill of vc 1 to 16, then push and pop in the same cycle -> count stays 16 and no overflow.
- Push a BODY on IDLE vc 3 -> framing_err_out[3]=1 and the flit is stored (head_valid_out[3]=1).
- With vc 0 holding 5 flits and vc 1 holding 2, pulse reset for one cycle:
  - Immediately, all outputs return to their reset values.
  - A subsequent push of HEADER on vc 1 raises no framing error.

Source files
------------

// File: rtl/router_input_vc_buffer.sv
// Router input VC buffer: steers incoming flits into per-VC FWFT FIFOs,
// exposes each VC head, returns on/off backpressure and checks packet framing.
// Flit layout (MSB..LSB): {flit_type[1:0], vc_id[VC_W-1:0], payload[DATA_W-1:0]}
// flit_type: 0=HEADER 1=BODY 2=TAIL 3=HT (single-flit packet)

module router_vc_fifo #(
   parameter int FIFO_DEPTH = 16,
   parameter int OFF_SLACK  = 3,
   parameter int FLIT_W     = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop_req,
   input  logic [FLIT_W-1:0] flit,
   output logic [FLIT_W-1:0] head,
   output logic              head_valid,
   output logic              on_off,
   output logic              overflow_err,
   output logic              framing_err
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [1:0] T_HEADER = 2'd0;
   localparam logic [1:0] T_BODY   = 2'd1;
   localparam logic [1:0] T_TAIL   = 2'd2;
   localparam logic [1:0] T_HT     = 2'd3;
   localparam logic IDLE   = 1'b0;
   localparam logic IN_PKT = 1'b1;

   logic [FLIT_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [CNT_W-1:0]  cnt, cnt_nxt, free_nxt;
   logic              full, do_pop, do_push, state;
   logic [1:0]        ftype;

   assign full       = (cnt == CNT_W'(FIFO_DEPTH));
   assign head_valid = (cnt != '0);
   // pops on empty are ignored; a pop on a full FIFO makes room for a same-cycle push
   assign do_pop     = pop_req && head_valid;
   assign do_push    = push && (!full || do_pop);
   assign head       = mem[rd_ptr];
   assign ftype      = flit[FLIT_W-1 -: 2];

   // next occupancy and the free-slot count that drives backpressure
   always_comb begin
      cnt_nxt = cnt;
      if (do_push && !do_pop)      cnt_nxt = cnt + CNT_W'(1);
      else if (do_pop && !do_push) cnt_nxt = cnt - CNT_W'(1);
      free_nxt = CNT_W'(FIFO_DEPTH) - cnt_nxt;
   end

   // flit storage, no reset needed: contents are only meaningful below the count
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= flit;
   end

   // pointers, count, registered on/off and sticky overflow
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         cnt          <= '0;
         on_off       <= 1'b0;
         overflow_err <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         cnt    <= cnt_nxt;
         on_off <= (free_nxt <= CNT_W'(OFF_SLACK));
         if (push && !do_push) overflow_err <= 1'b1;
      end
   end

   // framing checker, advanced only by accepted pushes; bad flits are still stored
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         framing_err <= 1'b0;
      end else if (do_push) begin
         if (state == IDLE) begin
            if (ftype == T_HEADER) state <= IN_PKT;
            else if (ftype == T_BODY || ftype == T_TAIL) framing_err <= 1'b1;
         end else begin
            if (ftype == T_TAIL) state <= IDLE;
            else if (ftype == T_HEADER || ftype == T_HT) framing_err <= 1'b1;
         end
      end
   end
endmodule

module router_input_vc_buffer #(
   parameter int VC_NUM     = 4,
   parameter int FIFO_DEPTH = 16,
   parameter int OFF_SLACK  = 3,
   parameter int DATA_W     = 16,
   localparam int VC_W      = $clog2(VC_NUM),
   localparam int FLIT_W    = 2 + VC_W + DATA_W
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           wr_en_in,
   input  logic [FLIT_W-1:0]              flit_in,
   input  logic [VC_NUM-1:0]              rd_en_in,
   output logic [VC_NUM-1:0][FLIT_W-1:0]  head_flit_out,
   output logic [VC_NUM-1:0]              head_valid_out,
   output logic [VC_NUM-1:0]              on_off_out,
   output logic [VC_NUM-1:0]              overflow_err_out,
   output logic [VC_NUM-1:0]              framing_err_out
);
   logic [VC_W-1:0] vc_id;
   assign vc_id = flit_in[DATA_W +: VC_W];

   for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      router_vc_fifo #(
         .FIFO_DEPTH (FIFO_DEPTH),
         .OFF_SLACK  (OFF_SLACK),
         .FLIT_W     (FLIT_W)
      ) u_fifo (
         .clk          (clk),
         .reset        (reset),
         .push         (wr_en_in && (vc_id == VC_W'(v))),
         .pop_req      (rd_en_in[v]),
         .flit         (flit_in),
         .head         (head_flit_out[v]),
         .head_valid   (head_valid_out[v]),
         .on_off       (on_off_out[v]),
         .overflow_err (overflow_err_out[v]),
         .framing_err  (framing_err_out[v])
      );
   end
endmodule
